// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer: drives one shared external 1-digit BCD
// adder, LS digit first, one digit per clock, with a start/done handshake.
module bcd_serial_add_ctrl #(
  parameter int unsigned NDIG = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [4*NDIG-1:0]   a_i,
  input  logic [4*NDIG-1:0]   b_i,
  input  logic                cin_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [4*NDIG-1:0]   sum_o,
  output logic                cout_o,
  output logic [3:0]          add_a_o,
  output logic [3:0]          add_b_o,
  output logic                add_cin_o,
  input  logic [3:0]          add_ms_i,
  input  logic [3:0]          add_ls_i
);

  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       carry_q, carry_d;
  logic [NDIG-1:0][3:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                       cout_q, cout_d;
  logic                       err_q, err_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [NDIG-1:0][3:0]       a_dig_c, b_dig_c;
  logic [NDIG-1:0]            bad_dig_c;
  logic                       any_bad_c;
  logic                       last_c;
  logic                       unused_ms_c;

  // Only the LSB of the adder's carry digit is meaningful.
  assign unused_ms_c = ^add_ms_i[3:1];

  assign a_dig_c = a_i;
  assign b_dig_c = b_i;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig_chk
    assign bad_dig_c[g] = (a_dig_c[g] > 4'd9) | (b_dig_c[g] > 4'd9);
  end
  assign any_bad_c = |bad_dig_c;
  assign last_c    = (idx_q == IDX_W'(NDIG - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = any_bad_c ? S_DONE : S_ADD;
      S_ADD:   if (last_c)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Adder drive and datapath updates
  always_comb begin
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    err_d     = err_q;
    add_a_o   = 4'd0;
    add_b_o   = 4'd0;
    add_cin_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = any_bad_c;
        end
      end
      S_ADD: begin
        add_a_o       = a_q[idx_q];
        add_b_o       = b_q[idx_q];
        add_cin_o     = carry_q;
        sum_d[idx_q]  = add_ls_i;
        carry_d       = add_ms_i[0];
        idx_d         = idx_q + IDX_W'(1);
        if (last_c) begin
          cout_d = add_ms_i[0];
          idx_d  = '0;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == S_ADD);
    done_d = (state_d == S_DONE);
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl with a behavioural 1-digit BCD adder
// on the add_* ports and a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic           clk, rst_n, start_i, cin_i;
  logic [W-1:0]   a_i, b_i, sum_o;
  logic           busy_o, done_o, err_o, cout_o, add_cin_o;
  logic [3:0]     add_a_o, add_b_o, add_ms_i, add_ls_i;
  logic [2:0]     ms_junk;
  logic [4:0]     dsum;

  int errors = 0;
  int checks = 0;

  logic [3:0] obs_a [8];
  logic [3:0] obs_b [8];
  logic       obs_c [8];
  int         n_obs;

  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .sum_o(sum_o), .cout_o(cout_o),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_cin_o(add_cin_o),
    .add_ms_i(add_ms_i), .add_ls_i(add_ls_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared single-digit BCD adder; upper carry-digit bits carry junk the DUT must ignore.
  always_comb begin
    dsum = 5'(add_a_o) + 5'(add_b_o) + 5'(add_cin_o);
    if (dsum > 5'd9) begin
      add_ms_i = {ms_junk, 1'b1};
      add_ls_i = 4'(dsum - 5'd10);
    end else begin
      add_ms_i = {ms_junk, 1'b0};
      add_ls_i = dsum[3:0];
    end
  end

  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, output logic [W-1:0] s,
                                  output logic c, output logic e);
    int unsigned av, bv, tot, r, lim;
    logic [3:0] d;
    av = 0; bv = 0; lim = 1; s = '0; c = 1'b0; e = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = 4'(a >> (4 * i));
      if (d > 4'd9) e = 1'b1;
      av = av * 10 + 32'(d);
      d = 4'(b >> (4 * i));
      if (d > 4'd9) e = 1'b1;
      bv = bv * 10 + 32'(d);
      lim = lim * 10;
    end
    if (!e) begin
      tot = av + bv + 32'(cin);
      c   = (tot >= lim);
      r   = tot % lim;
      for (int i = 0; i < NDIG; i++) begin
        s = s | (W'(r % 10) << (4 * i));
        r = r / 10;
      end
    end
  endfunction

  // Runs one request; reports result, latency (0 = timeout), busy cycles, done pulses.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit disturb, input bit immediate,
                        output logic [W-1:0] s, output logic c, output logic e,
                        output int lat, output int busy_n, output int done_n);
    s = '0; c = 1'b0; e = 1'b0; lat = 0; busy_n = 0; done_n = 0; n_obs = 0;
    if (!immediate) @(negedge clk);
    a_i = a; b_i = b; cin_i = cin; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
    for (int t = 1; t <= 30; t++) begin
      if (busy_o) begin
        busy_n++;
        if (n_obs < 8) begin
          obs_a[n_obs] = add_a_o; obs_b[n_obs] = add_b_o; obs_c[n_obs] = add_cin_o;
          n_obs++;
        end
      end
      if (done_o) begin
        done_n++;
        if (lat == 0) begin lat = t; s = sum_o; c = cout_o; e = err_o; end
      end
      if (disturb && t == 2) begin start_i = 1'b1; a_i = 16'h9999; end
      if (disturb && t == 3) start_i = 1'b0;
      if (lat != 0 && t >= lat + 1) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; ms_junk = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, cout_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {busy_o, done_o, err_o, cout_o});
    end
    checks++;
    if (sum_o !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum_o); end
    checks++;
    if ({add_a_o, add_b_o, add_cin_o} !== 9'd0) begin
      errors++; $display("FAIL reset_adder got=%h/%h/%b exp=0/0/0", add_a_o, add_b_o, add_cin_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic c, e; int lat, bn, dn;
    run_op(16'h1234, 16'h8766, 1'b0, 1'b0, 1'b0, s, c, e, lat, bn, dn);
    checks++; if (lat !== NDIG + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, NDIG + 1); end
    checks++; if (bn !== NDIG) begin errors++; $display("FAIL basic_busy got=%0d exp=%0d", bn, NDIG); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", dn); end
    checks++; if ({s, c, e} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL basic_result got=%h c=%b e=%b exp=0000 c=1 e=0", s, c, e);
    end
    checks++; if (sum_o !== 16'h0000 || cout_o !== 1'b1) begin
      errors++; $display("FAIL basic_hold got=%h c=%b exp=0000 c=1", sum_o, cout_o);
    end
  endtask

  task automatic test_carry_edges();
    logic [W-1:0] s; logic c, e; int lat, bn, dn;
    run_op(16'h9999, 16'h0000, 1'b1, 1'b0, 1'b0, s, c, e, lat, bn, dn);
    checks++; if ({s, c, e} !== {16'h0000, 1'b1, 1'b0} || lat !== NDIG + 1) begin
      errors++; $display("FAIL carry_ripple got=%h c=%b e=%b lat=%0d exp=0000 c=1 e=0 lat=%0d", s, c, e, lat, NDIG + 1);
    end
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, s, c, e, lat, bn, dn);
    checks++; if ({s, c, e} !== {16'h0000, 1'b0, 1'b0} || lat !== NDIG + 1) begin
      errors++; $display("FAIL carry_zero got=%h c=%b e=%b lat=%0d exp=0000 c=0 e=0 lat=%0d", s, c, e, lat, NDIG + 1);
    end
  endtask

  task automatic test_digits();
    logic [W-1:0] s; logic c, e; int lat, bn, dn;
    logic [3:0] ea [4]; logic [3:0] eb [4]; logic ec [4];
    ea = '{4'd9, 4'd5, 4'd4, 4'd0}; eb = '{4'd7, 4'd2, 4'd0, 4'd0}; ec = '{1'b0, 1'b1, 1'b0, 1'b0};
    run_op(16'h0459, 16'h0027, 1'b0, 1'b0, 1'b0, s, c, e, lat, bn, dn);
    checks++; if ({s, c, e} !== {16'h0486, 1'b0, 1'b0}) begin
      errors++; $display("FAIL digits_result got=%h c=%b e=%b exp=0486 c=0 e=0", s, c, e);
    end
    checks++; if (n_obs !== 4) begin errors++; $display("FAIL digits_count got=%0d exp=4", n_obs); end
    for (int i = 0; i < 4 && i < n_obs; i++) begin
      checks++;
      if (obs_a[i] !== ea[i] || obs_b[i] !== eb[i] || obs_c[i] !== ec[i]) begin
        errors++;
        $display("FAIL digits_drive[%0d] got=%0d/%0d/%b exp=%0d/%0d/%b", i, obs_a[i], obs_b[i], obs_c[i], ea[i], eb[i], ec[i]);
      end
    end
  endtask

  task automatic test_err();
    logic [W-1:0] s; logic c, e; int lat, bn, dn;
    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0, s, c, e, lat, bn, dn);
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency got=%0d exp=1", lat); end
    checks++; if (bn !== 0) begin errors++; $display("FAIL err_busy got=%0d exp=0", bn); end
    checks++; if ({s, c, e} !== {16'h0000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL err_result got=%h c=%b e=%b exp=0000 c=0 e=1", s, c, e);
    end
    @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_hold got=%b exp=1", err_o); end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, s, c, e, lat, bn, dn);
    checks++; if ({s, e} !== {16'h0002, 1'b0}) begin
      errors++; $display("FAIL err_clear got=%h e=%b exp=0002 e=0", s, e);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] s; logic c, e; int lat, bn, dn;
    run_op(16'h0459, 16'h0027, 1'b0, 1'b1, 1'b0, s, c, e, lat, bn, dn);
    checks++; if ({s, c, e} !== {16'h0486, 1'b0, 1'b0} || dn !== 1 || lat !== NDIG + 1) begin
      errors++; $display("FAIL ignore_start got=%h c=%b e=%b dn=%0d lat=%0d exp=0486 c=0 e=0 dn=1 lat=%0d", s, c, e, dn, lat, NDIG + 1);
    end
    repeat (3) @(negedge clk);
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL ignore_start_idle got busy=%b done=%b exp=0/0", busy_o, done_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s, es; logic c, e, ecout, ee; int lat, bn, dn, dseen;
    @(negedge clk);
    a_i = 16'h0459; b_i = 16'h0027; cin_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, cout_o, add_cin_o} !== 5'd0 || sum_o !== '0 || {add_a_o, add_b_o} !== 8'd0) begin
      errors++; $display("FAIL reset_mid_clear got busy=%b done=%b sum=%h add_a=%h exp all 0", busy_o, done_o, sum_o, add_a_o);
    end
    dseen = 0;
    repeat (3) begin @(negedge clk); if (done_o) dseen++; end
    rst_n = 1'b1;
    repeat (NDIG + 2) begin @(negedge clk); if (done_o) dseen++; end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL reset_mid_no_done got=%0d exp=0", dseen); end
    ref_add(16'h5678, 16'h4321, 1'b1, es, ecout, ee);
    run_op(16'h5678, 16'h4321, 1'b1, 1'b0, 1'b0, s, c, e, lat, bn, dn);
    checks++; if ({s, c, e} !== {es, ecout, ee} || lat !== NDIG + 1) begin
      errors++; $display("FAIL reset_mid_fresh got=%h c=%b e=%b lat=%0d exp=%h c=%b e=%b", s, c, e, lat, es, ecout, ee);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s, es; logic c, e, ec, ee; int lat, bn, dn;
    run_op(16'h0999, 16'h0001, 1'b0, 1'b0, 1'b0, s, c, e, lat, bn, dn);
    checks++; if ({s, c} !== {16'h1000, 1'b0}) begin
      errors++; $display("FAIL b2b_first got=%h c=%b exp=1000 c=0", s, c);
    end
    ref_add(16'h8888, 16'h2222, 1'b1, es, ec, ee);
    run_op(16'h8888, 16'h2222, 1'b1, 1'b0, 1'b1, s, c, e, lat, bn, dn);
    checks++; if ({s, c, e} !== {es, ec, ee} || lat !== NDIG + 1) begin
      errors++; $display("FAIL b2b_second got=%h c=%b e=%b lat=%0d exp=%h c=%b e=%b lat=%0d", s, c, e, lat, es, ec, ee, NDIG + 1);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s, es; logic cin, c, e, ec, ee; int lat, bn, dn, elat;
    for (int n = 0; n < 40; n++) begin
      a = '0; b = '0;
      for (int i = 0; i < NDIG; i++) begin
        a = a | (W'($urandom_range(0, 9)) << (4 * i));
        b = b | (W'($urandom_range(0, 9)) << (4 * i));
      end
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) a = a | (W'($urandom_range(10, 15)) << (4 * $urandom_range(0, NDIG - 1)));
        else                           b = b | (W'($urandom_range(10, 15)) << (4 * $urandom_range(0, NDIG - 1)));
      end
      cin = 1'($urandom);
      ms_junk = 3'($urandom);
      ref_add(a, b, cin, es, ec, ee);
      elat = ee ? 1 : NDIG + 1;
      run_op(a, b, cin, 1'b0, 1'($urandom), s, c, e, lat, bn, dn);
      checks++;
      if ({s, c, e} !== {es, ec, ee} || lat !== elat || dn !== 1) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b got=%h c=%b e=%b lat=%0d dn=%0d exp=%h c=%b e=%b lat=%0d",
                 n, a, b, cin, s, c, e, lat, dn, es, ec, ee, elat);
      end
    end
    ms_junk = 3'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_edges();
    test_digits();
    test_err();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
